// File: rtl/astro_cart_pkg.sv
// Shared types and helpers for the Astrocade cartridge loader.
// Holds the loader state encoding, default window geometry and the
// mirror-block sizing function used when an image is shorter than the window.
package astro_cart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_PAD       = 3'd2,
        ST_MIRROR_RD = 3'd3,
        ST_MIRROR_WR = 3'd4,
        ST_DONE      = 3'd5
    } cart_ld_state_t;

    localparam int unsigned CART_AW   = 32'd13;
    localparam int unsigned CART_WIN  = 32'd1 << CART_AW;
    localparam int unsigned MIN_BLOCK = 32'd2048;

    // Smallest power of two >= size, never below min_blk and never above win.
    // min_blk and win are powers of two with min_blk <= win.
    function automatic logic [16:0] blk_size(input logic [16:0] size,
                                             input logic [16:0] min_blk,
                                             input logic [16:0] win);
        logic [16:0] b;
        b = min_blk;
        for (int i = 0; i < 17; i++) begin
            if ((b < size) && (b < win)) begin
                b = {b[15:0], 1'b0};
            end else begin
                b = b;
            end
        end
        if (b > win) begin
            b = win;
        end else begin
            b = b;
        end
        return b;
    endfunction

endpackage

// File: rtl/cart_loader.sv
// Cartridge loader: writes the HPS download stream into the cart RAM,
// then pads and mirrors short images across the whole window so the
// cart bus decode never has to know the image size.
module cart_loader #(
    parameter logic [7:0]  CART_INDEX = 8'd1,
    parameter int unsigned AW         = 32'd13,
    parameter int unsigned MIN_BLOCK  = 32'd2048,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic [7:0]    ioctl_index,
    output logic          ioctl_wait,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_dout,
    output logic          mem_own,
    output logic          busy,
    output logic          cart_valid,
    output logic [15:0]   cart_size,
    output logic          overflow
);

    import astro_cart_pkg::*;

    // Window size, last window address and minimum block, all AW+1 bits so
    // the full window size itself is representable (ptr never wraps).
    localparam logic [AW:0] WIN_V  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LAST_V = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0] ONE_V  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] MINB_V = MIN_BLOCK[AW:0];
    localparam logic [15:0] WIN16  = 16'(WIN_V);

    cart_ld_state_t state_r, state_nxt_s;

    logic [AW:0]   ptr_r, ptr_nxt_s;
    logic [AW:0]   blk_r, blk_nxt_s;
    logic [15:0]   cart_size_r, cart_size_nxt_s;
    logic          overflow_r, overflow_nxt_s;
    logic          cart_valid_r, cart_valid_nxt_s;

    logic          start_s;
    logic          in_range_s;
    logic [AW:0]   cand_s;
    logic [15:0]   cand16_s;
    logic [16:0]   blk_full_s;
    logic [AW:0]   blk_mask_s;
    logic [AW:0]   ptr_inc_s;
    logic          busy_s;
    logic [AW-1:0] mem_addr_s;
    logic [7:0]    mem_din_s;
    logic          mem_we_s;

    // Derived helper values shared by the next-state logic.
    always_comb begin
        start_s    = ioctl_download && (ioctl_index == CART_INDEX);
        in_range_s = (ioctl_addr[24:AW] == '0);
        cand_s     = {1'b0, ioctl_addr[AW-1:0]} + ONE_V;
        cand16_s   = 16'(cand_s);
        blk_full_s = blk_size(17'(cart_size_r), 17'(MINB_V), 17'(WIN_V));
        blk_mask_s = blk_r - ONE_V;
        ptr_inc_s  = ptr_r + ONE_V;
        busy_s     = (state_r == ST_PAD) || (state_r == ST_MIRROR_RD) ||
                     (state_r == ST_MIRROR_WR);
    end

    // Next-state, datapath updates and RAM port drive.
    always_comb begin
        state_nxt_s      = state_r;
        ptr_nxt_s        = ptr_r;
        blk_nxt_s        = blk_r;
        cart_size_nxt_s  = cart_size_r;
        overflow_nxt_s   = overflow_r;
        cart_valid_nxt_s = cart_valid_r;
        mem_addr_s       = '0;
        mem_din_s        = 8'h00;
        mem_we_s         = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_nxt_s      = ST_LOAD;
                    cart_size_nxt_s  = 16'd0;
                    overflow_nxt_s   = 1'b0;
                    cart_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end

            ST_LOAD: begin
                if (!ioctl_download) begin
                    // Download finished: decide how much post-processing is needed.
                    if (cart_size_r == 16'd0) begin
                        state_nxt_s      = ST_IDLE;
                        cart_valid_nxt_s = 1'b0;
                    end else if (cart_size_r >= WIN16) begin
                        state_nxt_s      = ST_DONE;
                        cart_valid_nxt_s = 1'b1;
                    end else begin
                        blk_nxt_s = blk_full_s[AW:0];
                        if (17'(cart_size_r) < blk_full_s) begin
                            state_nxt_s = ST_PAD;
                            ptr_nxt_s   = cart_size_r[AW:0];
                        end else begin
                            state_nxt_s = ST_MIRROR_RD;
                            ptr_nxt_s   = blk_full_s[AW:0];
                        end
                    end
                end else if (ioctl_wr) begin
                    if (in_range_s) begin
                        mem_we_s   = 1'b1;
                        mem_addr_s = ioctl_addr[AW-1:0];
                        mem_din_s  = ioctl_dout;
                        if (cand16_s > cart_size_r) begin
                            cart_size_nxt_s = cand16_s;
                        end else begin
                            cart_size_nxt_s = cart_size_r;
                        end
                    end else begin
                        overflow_nxt_s  = 1'b1;
                        cart_size_nxt_s = WIN16;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end

            ST_PAD: begin
                mem_we_s   = 1'b1;
                mem_addr_s = ptr_r[AW-1:0];
                mem_din_s  = PAD_BYTE;
                if (ptr_r == blk_mask_s) begin
                    // A block equal to the window leaves nothing to mirror.
                    if (blk_r == WIN_V) begin
                        state_nxt_s      = ST_DONE;
                        cart_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_MIRROR_RD;
                        ptr_nxt_s   = blk_r;
                    end
                end else begin
                    ptr_nxt_s = ptr_inc_s;
                end
            end

            ST_MIRROR_RD: begin
                // Read the source byte from the first block; data returns next cycle.
                mem_addr_s  = ptr_r[AW-1:0] & blk_mask_s[AW-1:0];
                state_nxt_s = ST_MIRROR_WR;
            end

            ST_MIRROR_WR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = ptr_r[AW-1:0];
                mem_din_s  = mem_dout;
                if (ptr_r == LAST_V) begin
                    state_nxt_s      = ST_DONE;
                    cart_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_MIRROR_RD;
                    ptr_nxt_s   = ptr_inc_s;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any fill in progress.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= '0;
            blk_r        <= '0;
            cart_size_r  <= 16'd0;
            overflow_r   <= 1'b0;
            cart_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            ptr_r        <= ptr_nxt_s;
            blk_r        <= blk_nxt_s;
            cart_size_r  <= cart_size_nxt_s;
            overflow_r   <= overflow_nxt_s;
            cart_valid_r <= cart_valid_nxt_s;
        end
    end

    // Output drive; HPS is held off exactly while post-processing runs.
    always_comb begin
        busy       = busy_s;
        ioctl_wait = busy_s;
        mem_own    = ioctl_download | busy_s;
        mem_addr   = mem_addr_s;
        mem_din    = mem_din_s;
        mem_we     = mem_we_s;
        cart_valid = cart_valid_r;
        cart_size  = cart_size_r;
        overflow   = overflow_r;
    end

endmodule
